// File: rtl/roulette_selector_if.sv
// Handshake and data bundle between the GA controller and the roulette selector.
// With ROULETTE_EXCLUDE_EN defined, the bundle also carries the exclusion request.
interface roulette_selector_if #(
    parameter int POPULATION_SIZE = 16,
    parameter int ADDR_WIDTH      = $clog2(POPULATION_SIZE),
    parameter int FITNESS_WIDTH   = 10,
    parameter int TOTAL_WIDTH     = FITNESS_WIDTH + ADDR_WIDTH
);
    logic                     start_selection;
    logic [FITNESS_WIDTH-1:0] fitness_values [POPULATION_SIZE];
    logic [TOTAL_WIDTH-1:0]   total_fitness;
    logic                     seed_load;
    logic [15:0]              seed_value;
    logic [ADDR_WIDTH-1:0]    selected_parent;
    logic                     selection_done;
    logic                     busy;
`ifdef ROULETTE_EXCLUDE_EN
    logic                     exclude_valid;
    logic [ADDR_WIDTH-1:0]    exclude_idx;

    modport master (
        output start_selection, fitness_values, total_fitness, seed_load, seed_value,
               exclude_valid, exclude_idx,
        input  selected_parent, selection_done, busy
    );
    modport slave (
        input  start_selection, fitness_values, total_fitness, seed_load, seed_value,
               exclude_valid, exclude_idx,
        output selected_parent, selection_done, busy
    );
`else
    modport master (
        output start_selection, fitness_values, total_fitness, seed_load, seed_value,
        input  selected_parent, selection_done, busy
    );
    modport slave (
        input  start_selection, fitness_values, total_fitness, seed_load, seed_value,
        output selected_parent, selection_done, busy
    );
`endif
endinterface

// File: rtl/roulette_selector.sv
// Fitness-proportionate parent selector: LFSR draw scaled to [0,total), then a linear scan.
// Optional ROULETTE_EXCLUDE_EN adds a per-run excluded index.
//
// state | meaning
// IDLE  | waiting for start_selection; seed_load accepted here
// SCALE | threshold = (lfsr * total) >> 16, or uniform pick when total is 0
// SCAN  | accumulate one fitness entry per cycle until the sum exceeds threshold
// DONE  | selection_done pulse, selected_parent valid
module roulette_selector #(
    parameter int          POPULATION_SIZE = 16,
    parameter int          ADDR_WIDTH      = $clog2(POPULATION_SIZE),
    parameter int          FITNESS_WIDTH   = 10,
    parameter int          TOTAL_WIDTH     = FITNESS_WIDTH + ADDR_WIDTH,
    parameter logic [15:0] SEED            = 16'hACE1
) (
    input logic               clk,
    input logic               rst_n,
    roulette_selector_if.slave bus
);
    localparam logic [15:0]           LFSR_MASK = 16'hB400;
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX  = ADDR_WIDTH'(POPULATION_SIZE - 1);

    typedef enum logic [1:0] {IDLE, SCALE, SCAN, DONE} state_t;

    state_t                    state, state_next;
    logic [15:0]               lfsr, lfsr_next;
    logic [TOTAL_WIDTH-1:0]    acc, acc_next, threshold, eff_total;
    logic [TOTAL_WIDTH:0]      sum_wide;
    logic [16+TOTAL_WIDTH-1:0] product;
    logic [FITNESS_WIDTH-1:0]  fit_cur;
    logic [ADDR_WIDTH-1:0]     idx, sel, pick, fall_idx;
    logic                      hit, last;
`ifdef ROULETTE_EXCLUDE_EN
    logic                      excl_valid;
    logic [ADDR_WIDTH-1:0]     excl_idx;
    logic [TOTAL_WIDTH-1:0]    excl_fit;
`endif

    always_comb begin
        fit_cur   = bus.fitness_values[idx];
        eff_total = bus.total_fitness;
        pick      = lfsr[ADDR_WIDTH-1:0];
        fall_idx  = LAST_IDX;
`ifdef ROULETTE_EXCLUDE_EN
        excl_fit  = TOTAL_WIDTH'(bus.fitness_values[excl_idx]);
        if (excl_valid) begin
            if (idx == excl_idx) fit_cur = '0;
            eff_total = (bus.total_fitness > excl_fit) ? bus.total_fitness - excl_fit : '0;
            // Uniform pick must never land on the excluded entry.
            if (pick == excl_idx) pick = pick + ADDR_WIDTH'(1);
            if (excl_idx == LAST_IDX) fall_idx = LAST_IDX - ADDR_WIDTH'(1);
        end
`endif
        sum_wide  = {1'b0, acc} + (TOTAL_WIDTH+1)'(fit_cur);
        acc_next  = sum_wide[TOTAL_WIDTH] ? '1 : sum_wide[TOTAL_WIDTH-1:0];
        hit       = acc_next > threshold;
        last      = idx == LAST_IDX;
        product   = {{TOTAL_WIDTH{1'b0}}, lfsr} * {16'h0000, eff_total};
        lfsr_next = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_MASK : 16'h0000);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.start_selection) state_next = SCALE;
            SCALE:   state_next = (eff_total == '0) ? DONE : SCAN;
            SCAN:    if (hit || last) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr       <= SEED;
            acc        <= '0;
            threshold  <= '0;
            idx        <= '0;
            sel        <= '0;
`ifdef ROULETTE_EXCLUDE_EN
            excl_valid <= 1'b0;
            excl_idx   <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    // A seed arriving with start is used by that same run.
                    if (bus.seed_load && bus.seed_value != 16'h0000) lfsr <= bus.seed_value;
                    if (bus.start_selection) begin
                        acc <= '0;
                        idx <= '0;
`ifdef ROULETTE_EXCLUDE_EN
                        excl_valid <= bus.exclude_valid;
                        excl_idx   <= bus.exclude_idx;
`endif
                    end
                end
                SCALE: begin
                    lfsr <= lfsr_next;
                    if (eff_total == '0) sel <= pick;
                    else                 threshold <= TOTAL_WIDTH'(product >> 16);
                end
                SCAN: begin
                    acc <= acc_next;
                    if (hit)       sel <= idx;
                    else if (last) sel <= fall_idx;
                    else           idx <= idx + ADDR_WIDTH'(1);
                end
                default: ;
            endcase
        end
    end

    assign bus.selected_parent = sel;
    assign bus.selection_done  = (state == DONE);
    assign bus.busy            = (state != IDLE);
endmodule

// File: tb/tb_roulette_selector.sv
// Directed bench for roulette_selector with hand-computed winners and latencies.
module tb_roulette_selector;
    logic clk = 1'b0;
    logic rst_n;
    int   vectors = 0;
    int   miscompares = 0;

    roulette_selector_if bus ();
    roulette_selector dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic set_all(input int v);
        for (int i = 0; i < 16; i++) bus.fitness_values[i] = 10'(v);
    endtask

    // Starts a run from IDLE; returns latency from the start cycle, winner and busy-cycle count,
    // then steps into the following IDLE cycle. pulse_at re-raises start in that cycle only.
    task automatic run_req(input logic ld, input logic [15:0] sv, input int pulse_at,
                           output int lat, output int sel, output int busy_cnt);
        bus.seed_load = ld;
        bus.seed_value = sv;
        bus.start_selection = 1'b1;
        tick();
        bus.start_selection = 1'b0;
        bus.seed_load = 1'b0;
        lat = 1;
        busy_cnt = 0;
        while (!bus.selection_done && lat < 40) begin
            busy_cnt += int'(bus.busy);
            bus.start_selection = (lat == pulse_at);
            tick();
            lat++;
        end
        bus.start_selection = 1'b0;
        busy_cnt += int'(bus.busy);
        sel = int'(bus.selected_parent);
        tick();
    endtask

    int lat, sel, bcnt, n, extra;
    int dcyc [6];
    int dsel [6];

    initial begin
        rst_n = 1'b0;
        bus.start_selection = 1'b0;
        bus.seed_load = 1'b0;
        bus.seed_value = 16'h0000;
        bus.total_fitness = '0;
        set_all(0);
`ifdef ROULETTE_EXCLUDE_EN
        bus.exclude_valid = 1'b0;
        bus.exclude_idx = '0;
`endif
        #1;
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_done", 32'(bus.selection_done), 0);
        check("rst_sel", 32'(bus.selected_parent), 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // uniform 10s, total 160, seed 8000 -> threshold 80 -> index 8
        set_all(10);
        bus.total_fitness = 14'd160;
        run_req(1'b1, 16'h8000, 0, lat, sel, bcnt);
        check("t1_sel", 32'(sel), 8);
        check("t1_lat", 32'(lat), 11);
        check("t1_busy_cycles", 32'(bcnt), 11);
        check("t1_done_drop", 32'(bus.selection_done), 0);
        check("t1_busy_drop", 32'(bus.busy), 0);

        // single nonzero entry at 5, threshold 0
        set_all(0);
        bus.fitness_values[5] = 10'd100;
        bus.total_fitness = 14'd100;
        run_req(1'b1, 16'h0001, 0, lat, sel, bcnt);
        check("t2_sel", 32'(sel), 5);
        check("t2_lat", 32'(lat), 8);

        // zero total -> uniform pick lfsr[3:0], no scan
        bus.total_fitness = 14'd0;
        run_req(1'b1, 16'h0003, 0, lat, sel, bcnt);
        check("t3_sel", 32'(sel), 3);
        check("t3_lat", 32'(lat), 2);

        // inconsistent total 200, seed FFFF -> threshold 199, fall-through
        set_all(10);
        bus.total_fitness = 14'd200;
        run_req(1'b1, 16'hFFFF, 0, lat, sel, bcnt);
        check("t4_sel", 32'(sel), 15);
        check("t4_lat", 32'(lat), 18);

        // zero seed ignored: LFSR moved FFFF -> CBFF, pick 15
        bus.total_fitness = 14'd0;
        run_req(1'b1, 16'h0000, 0, lat, sel, bcnt);
        check("t4b_zero_seed_sel", 32'(sel), 15);

        // start held high: winners 8,4,2,1,0,0 done at cycles 11,19,25,30,34,38
        bus.total_fitness = 14'd160;
        bus.seed_load = 1'b1;
        bus.seed_value = 16'h8000;
        bus.start_selection = 1'b1;
        tick();
        bus.seed_load = 1'b0;
        n = 0;
        for (int c = 1; c <= 40; c++) begin
            if (bus.selection_done) begin
                if (n < 6) begin
                    dcyc[n] = c;
                    dsel[n] = int'(bus.selected_parent);
                end
                n++;
            end
            tick();
        end
        bus.start_selection = 1'b0;
        for (int k = 0; k < 30 && bus.busy; k++) tick();
        tick();
        check("t5_done_count", 32'(n), 6);
        check("t5_sel0", 32'(dsel[0]), 8);
        check("t5_sel1", 32'(dsel[1]), 4);
        check("t5_sel2", 32'(dsel[2]), 2);
        check("t5_sel3", 32'(dsel[3]), 1);
        check("t5_sel4", 32'(dsel[4]), 0);
        check("t5_cyc0", 32'(dcyc[0]), 11);
        check("t5_gap1", 32'(dcyc[1] - dcyc[0]), 8);
        check("t5_gap2", 32'(dcyc[2] - dcyc[1]), 6);
        check("t5_gap3", 32'(dcyc[3] - dcyc[2]), 5);
        check("t5_gap4", 32'(dcyc[4] - dcyc[3]), 4);
        check("t5_gap5", 32'(dcyc[5] - dcyc[4]), 4);

        // extra start pulse mid-SCAN is ignored
        run_req(1'b1, 16'h8000, 4, lat, sel, bcnt);
        check("t6_sel", 32'(sel), 8);
        check("t6_lat", 32'(lat), 11);
        extra = 0;
        for (int k = 0; k < 8; k++) begin
            extra += int'(bus.selection_done) + int'(bus.busy);
            tick();
        end
        check("t6_no_extra_run", 32'(extra), 0);

        // asynchronous reset during SCAN at idx 4
        bus.seed_load = 1'b1;
        bus.seed_value = 16'h8000;
        bus.start_selection = 1'b1;
        tick();
        bus.start_selection = 1'b0;
        bus.seed_load = 1'b0;
        repeat (5) tick();
        check("t7_busy_mid_scan", 32'(bus.busy), 1);
        check("t7_sel_held", 32'(bus.selected_parent), 8);
        #2 rst_n = 1'b0;
        #1;
        check("t7_rst_busy", 32'(bus.busy), 0);
        check("t7_rst_done", 32'(bus.selection_done), 0);
        check("t7_rst_sel", 32'(bus.selected_parent), 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        bus.total_fitness = 14'd0;
        run_req(1'b0, 16'h0000, 0, lat, sel, bcnt);
        check("t7_seed_restored", 32'(sel), 1);
        bus.total_fitness = 14'd160;
        run_req(1'b1, 16'h8000, 0, lat, sel, bcnt);
        check("t7_rerun_sel", 32'(sel), 8);
        check("t7_rerun_lat", 32'(lat), 11);

`ifdef ROULETTE_EXCLUDE_EN
        // exclude 8: effective total 150, threshold 75 -> index 7
        bus.exclude_valid = 1'b1;
        bus.exclude_idx = 4'd8;
        run_req(1'b1, 16'h8000, 0, lat, sel, bcnt);
        bus.exclude_valid = 1'b0;
        check("t8_excl_sel", 32'(sel), 7);
        check("t8_excl_lat", 32'(lat), 10);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
